// File: rtl/l2mp_log_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2mp_log_pkg
// Description : Shared types for the L2 main-pipe log arbiter. Holds the
//               60-bit debug record layout, the timestamp width and the
//               FIFO entry type {record, stamp}.
// Revision    : 1.0 - initial release
// ============================================================================
package l2mp_log_pkg;

  localparam int RECORD_W = 60;
  localparam int STAMP_W  = 64;

  // Field order is MSB to LSB of the packed record vector.
  typedef struct packed {
    logic [2:0]  meta_wway;
    logic        meta_wvalid;
    logic [7:0]  mshr_id;
    logic [7:0]  alloc_ptr;
    logic        alloc_valid;
    logic [2:0]  dir_way;
    logic        dir_hit;
    logic [8:0]  sset;
    logic [18:0] tag;
    logic [2:0]  opcode;
    logic [2:0]  channel;
    logic        mshr_task;
  } l2mp_record_t;

  typedef struct packed {
    l2mp_record_t         record;
    logic [STAMP_W-1:0]   stamp;
  } l2mp_entry_t;

endpackage
`default_nettype wire

// File: rtl/l2mp_log_fifo.sv
`default_nettype none
// ============================================================================
// Module      : l2mp_log_fifo
// Description : DEPTH-entry synchronous FIFO of timestamped log entries.
//               Supports push and pop in the same cycle, including a push
//               into a full FIFO that is being popped. Pointers carry one
//               extra wrap bit to tell full from empty.
// Ports       : clk, rst_n    - clock, asynchronous active-low reset
//               i_push/i_data - enqueue strobe and entry
//               i_pop         - dequeue strobe (head is o_data)
//               o_data        - head entry (valid when !o_empty)
//               o_full/o_empty- occupancy flags from registered pointers
// Revision    : 1.0 - initial release
// ============================================================================
module l2mp_log_fifo
  import l2mp_log_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  l2mp_entry_t i_data,
  input  logic        i_pop,
  output l2mp_entry_t o_data,
  output logic        o_full,
  output logic        o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  l2mp_entry_t r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO can still take a push when the head leaves this cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/l2mp_log_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l2mp_log_arbiter
// Description : Collects debug records from NUM_SLICES L2 main pipes,
//               timestamps them at capture, buffers them per slice and
//               drains one record per cycle round-robin to the writer.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               i_log_en       - global capture enable
//               i_in_valid     - per-slice record strobe
//               i_in_record    - packed records, slice 0 in the LSBs
//               o_in_ready     - per-slice accept (backpressure build only)
//               i_clr_drop     - pulse clearing all drop counters
//               o_out_en       - record valid toward the writer
//               o_out_record   - record fields
//               o_out_slice    - source slice of the record
//               o_out_stamp    - capture timestamp
//               o_drop_cnt     - per-slice saturating drop counters
// Config      : L2MP_LOG_BACKPRESSURE_EN - expose o_in_ready = !full and
//               count only refused handshakes instead of overflow drops.
// Revision    : 1.0 - initial release
// ============================================================================
module l2mp_log_arbiter
  import l2mp_log_pkg::*;
#(
  parameter int NUM_SLICES = 4,
  parameter int DEPTH      = 4,
  parameter int DROP_W     = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_log_en,
  input  logic [NUM_SLICES-1:0]            i_in_valid,
  input  logic [NUM_SLICES*RECORD_W-1:0]   i_in_record,
`ifdef L2MP_LOG_BACKPRESSURE_EN
  output logic [NUM_SLICES-1:0]            o_in_ready,
`endif
  input  logic                             i_clr_drop,
  output logic                             o_out_en,
  output logic [RECORD_W-1:0]              o_out_record,
  output logic [$clog2(NUM_SLICES)-1:0]    o_out_slice,
  output logic [STAMP_W-1:0]               o_out_stamp,
  output logic [NUM_SLICES*DROP_W-1:0]     o_drop_cnt
);

  localparam int SW = $clog2(NUM_SLICES);

  logic [STAMP_W-1:0]    r_stamp;
  logic [NUM_SLICES-1:0] w_full;
  logic [NUM_SLICES-1:0] w_empty;
  logic [NUM_SLICES-1:0] w_pop;
  l2mp_entry_t           w_rd_entry [NUM_SLICES];

  logic [SW-1:0]         r_rr_ptr;
  logic                  w_gnt_vld;
  logic [SW-1:0]         w_gnt_idx;
  logic [SW:0]           w_scan_sum;
  logic [SW-1:0]         w_scan_idx;
  l2mp_entry_t           w_gnt_entry;

  logic                  r_out_en;
  l2mp_record_t          r_out_record;
  logic [SW-1:0]         r_out_slice;
  logic [STAMP_W-1:0]    r_out_stamp;

  // Free-running capture timestamp; wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stamp <= '0;
    else        r_stamp <= r_stamp + 1'b1;
  end

  generate
    for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
      logic              w_accept;
      logic              w_push;
      logic              w_drop;
      l2mp_entry_t       w_wr_entry;
      logic [DROP_W-1:0] r_drop;

`ifdef L2MP_LOG_BACKPRESSURE_EN
      // Ready is from registered state only; a same-cycle pop is not used.
      assign w_accept      = !w_full[i];
      assign o_in_ready[i] = w_accept;
`else
      // A full FIFO still accepts when its head is granted this cycle.
      assign w_accept      = !w_full[i] || w_pop[i];
`endif
      assign w_push     = i_log_en && i_in_valid[i] && w_accept;
      assign w_drop     = i_log_en && i_in_valid[i] && !w_accept;
      assign w_wr_entry = {i_in_record[i*RECORD_W +: RECORD_W], r_stamp};
      assign w_pop[i]   = w_gnt_vld && (w_gnt_idx == SW'(i));

      l2mp_log_fifo #(
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_wr_entry),
        .i_pop   (w_pop[i]),
        .o_data  (w_rd_entry[i]),
        .o_full  (w_full[i]),
        .o_empty (w_empty[i])
      );

      // Clear has priority over a coincident increment; count saturates.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_drop <= '0;
        end else if (i_clr_drop) begin
          r_drop <= '0;
        end else if (w_drop && (r_drop != {DROP_W{1'b1}})) begin
          r_drop <= r_drop + 1'b1;
        end
      end

      assign o_drop_cnt[i*DROP_W +: DROP_W] = r_drop;
    end
  endgenerate

  // Round-robin search: first non-empty FIFO at or after r_rr_ptr, wrapping.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_scan_sum = '0;
    w_scan_idx = '0;
    for (int k = 0; k < NUM_SLICES; k++) begin
      w_scan_sum = {1'b0, r_rr_ptr} + (SW+1)'(k);
      if (w_scan_sum >= (SW+1)'(NUM_SLICES)) begin
        w_scan_sum = w_scan_sum - (SW+1)'(NUM_SLICES);
      end
      w_scan_idx = w_scan_sum[SW-1:0];
      if (!w_gnt_vld && !w_empty[w_scan_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan_idx;
      end
    end
  end

  assign w_gnt_entry = w_rd_entry[w_gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_out_en     <= 1'b0;
      r_out_record <= '0;
      r_out_slice  <= '0;
      r_out_stamp  <= '0;
    end else begin
      r_out_en <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_rr_ptr     <= (w_gnt_idx == SW'(NUM_SLICES-1)) ? '0 : w_gnt_idx + 1'b1;
        r_out_record <= w_gnt_entry.record;
        r_out_slice  <= w_gnt_idx;
        r_out_stamp  <= w_gnt_entry.stamp;
      end
    end
  end

  assign o_out_en     = r_out_en;
  assign o_out_record = r_out_record;
  assign o_out_slice  = r_out_slice;
  assign o_out_stamp  = r_out_stamp;

endmodule
`default_nettype wire

// File: tb/tb_l2mp_log_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2mp_log_arbiter
// Description : Directed self-checking bench for l2mp_log_arbiter with
//               NUM_SLICES=4, DEPTH=4, DROP_W=16. Inputs change and outputs
//               are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2mp_log_arbiter;
  import l2mp_log_pkg::*;

  localparam int NS = 4;
  localparam int DP = 4;
  localparam int DW = 16;

  logic                   clk    = 1'b0;
  logic                   rst_n  = 1'b0;
  logic                   log_en = 1'b0;
  logic                   clr    = 1'b0;
  logic [NS-1:0]          vld    = '0;
  logic [NS*RECORD_W-1:0] rec    = '0;
  logic                   out_en;
  logic [RECORD_W-1:0]    out_rec;
  logic [1:0]             out_slice;
  logic [STAMP_W-1:0]     out_stamp;
  logic [NS*DW-1:0]       drop;
`ifdef L2MP_LOG_BACKPRESSURE_EN
  logic [NS-1:0]          rdy;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] cyc;

  always #5 clk = ~clk;

  // Reference cycle count: equals the expected stamp value during a cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 64'd1;
  end

  l2mp_log_arbiter #(
    .NUM_SLICES (NS),
    .DEPTH      (DP),
    .DROP_W     (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_log_en     (log_en),
    .i_in_valid   (vld),
    .i_in_record  (rec),
`ifdef L2MP_LOG_BACKPRESSURE_EN
    .o_in_ready   (rdy),
`endif
    .i_clr_drop   (clr),
    .o_out_en     (out_en),
    .o_out_record (out_rec),
    .o_out_slice  (out_slice),
    .o_out_stamp  (out_stamp),
    .o_drop_cnt   (drop)
  );

  function automatic logic [RECORD_W-1:0] mkrec(int s, int q);
    return {36'hA5C30F1E7, 8'(s), 16'(q)};
  endfunction

  function automatic logic [DW-1:0] dcnt(int i);
    return drop[i*DW +: DW];
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    vld   = '0;
    clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_en !== 1'b0) begin n_err++; $display("FAIL reset_out_en: got %0b want 0", out_en); end
    n_vec++;
    if (out_rec !== '0 || out_slice !== 2'd0 || out_stamp !== 64'd0) begin
      n_err++; $display("FAIL reset_out_regs: rec=%h slice=%0d stamp=%0d want all 0", out_rec, out_slice, out_stamp);
    end
    n_vec++;
    if (drop !== '0) begin n_err++; $display("FAIL reset_drop: got %h want 0", drop); end
`ifdef L2MP_LOG_BACKPRESSURE_EN
    n_vec++;
    if (rdy !== 4'hF) begin n_err++; $display("FAIL reset_in_ready: got %b want 1111", rdy); end
`endif
    rst_n  = 1'b1;
    log_en = 1'b1;
  endtask

  task automatic test_all_slices();
    logic [63:0] t0;
    vld = '1;
    for (int i = 0; i < NS; i++) rec[i*RECORD_W +: RECORD_W] = mkrec(i, 16'h0030 + i);
    t0 = cyc;
    @(negedge clk);
    vld = '0;
    n_vec++;
    if (out_en !== 1'b0) begin n_err++; $display("FAIL all_latency: out_en=%0b want 0", out_en); end
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      n_vec++;
      if (out_en !== 1'b1 || out_slice !== 2'(k) || out_rec !== mkrec(k, 16'h0030 + k) || out_stamp !== t0) begin
        n_err++;
        $display("FAIL all_order[%0d]: en=%0b slice=%0d rec=%h stamp=%0d want en=1 slice=%0d rec=%h stamp=%0d",
                 k, out_en, out_slice, out_rec, out_stamp, k, mkrec(k, 16'h0030 + k), t0);
      end
    end
    @(negedge clk);
    n_vec++;
    if (out_en !== 1'b0) begin n_err++; $display("FAIL all_idle: out_en=%0b want 0", out_en); end
  endtask

  task automatic test_single_stamp100();
    l2mp_record_t r;
    l2mp_record_t o;
    logic [RECORD_W-1:0] exp_bits;
    int guard;
    guard = 0;
    while (cyc != 64'd100 && guard < 300) begin @(negedge clk); guard++; end
    n_vec++;
    if (cyc != 64'd100) begin n_err++; $display("FAIL single_wait: cycle %0d want 100", cyc); end
    r.meta_wway = 3'h5;  r.meta_wvalid = 1'b1; r.mshr_id = 8'hA7;  r.alloc_ptr = 8'h3C;
    r.alloc_valid = 1'b1; r.dir_way = 3'h2;    r.dir_hit = 1'b0;   r.sset = 9'h1F3;
    r.tag = 19'h5A5A5;    r.opcode = 3'h6;     r.channel = 3'h1;   r.mshr_task = 1'b1;
    exp_bits = {3'h5, 1'b1, 8'hA7, 8'h3C, 1'b1, 3'h2, 1'b0, 9'h1F3, 19'h5A5A5, 3'h6, 3'h1, 1'b1};
    rec = '0;
    rec[2*RECORD_W +: RECORD_W] = r;
    vld = 4'b0100;
    @(negedge clk);
    vld = '0;
    n_vec++;
    if (out_en !== 1'b0) begin n_err++; $display("FAIL single_latency: out_en=%0b want 0", out_en); end
    @(negedge clk);
    n_vec++;
    if (out_en !== 1'b1 || out_slice !== 2'd2 || out_stamp !== 64'd100) begin
      n_err++; $display("FAIL single_out: en=%0b slice=%0d stamp=%0d want en=1 slice=2 stamp=100", out_en, out_slice, out_stamp);
    end
    n_vec++;
    if (out_rec !== exp_bits) begin n_err++; $display("FAIL single_record: got %h want %h", out_rec, exp_bits); end
    o = out_rec;
    n_vec++;
    if (o.tag !== 19'h5A5A5 || o.sset !== 9'h1F3 || o.mshr_id !== 8'hA7) begin
      n_err++; $display("FAIL single_fields: tag=%h sset=%h mshr=%h want 5a5a5 1f3 a7", o.tag, o.sset, o.mshr_id);
    end
    @(negedge clk);
    n_vec++;
    if (out_en !== 1'b0) begin n_err++; $display("FAIL single_idle: out_en=%0b want 0", out_en); end
  endtask

  task automatic test_same_cycle_pop();
    int got;
    got = 0;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (out_en === 1'b1) begin
        n_vec++;
        if (out_slice !== 2'd1 || out_rec !== mkrec(1, 16'h0100 + got)) begin
          n_err++; $display("FAIL scp_record[%0d]: slice=%0d rec=%h want slice=1 rec=%h", got, out_slice, out_rec, mkrec(1, 16'h0100 + got));
        end
        got++;
      end
      vld = (j < 6) ? 4'b0010 : 4'b0000;
      rec[RECORD_W +: RECORD_W] = mkrec(1, 16'h0100 + j);
    end
    n_vec++;
    if (got != 6) begin n_err++; $display("FAIL scp_count: got %0d records want 6", got); end
    n_vec++;
    if (dcnt(1) !== 16'd0) begin n_err++; $display("FAIL scp_drop: got %0d want 0", dcnt(1)); end
  endtask

  task automatic test_overflow_drops();
    int win [NS];
    int tot [NS];
    int exp_acc [NS];
    int exp_drop [NS];
    exp_acc  = '{9, 9, 9, 8};
    exp_drop = '{11, 11, 11, 12};
    for (int i = 0; i < NS; i++) begin win[i] = 0; tot[i] = 0; end
    apply_reset();
    for (int j = 0; j < 60; j++) begin
      if (out_en === 1'b1) begin
        tot[out_slice]++;
        if (j >= 2 && j <= 21) win[out_slice]++;
      end
      vld = (j < 20) ? 4'hF : 4'h0;
      for (int i = 0; i < NS; i++) rec[i*RECORD_W +: RECORD_W] = mkrec(i, j);
      @(negedge clk);
    end
    for (int i = 0; i < NS; i++) begin
      n_vec++;
      if (win[i] != 5) begin n_err++; $display("FAIL ovf_grants[%0d]: got %0d want 5", i, win[i]); end
      n_vec++;
      if (tot[i] != exp_acc[i]) begin n_err++; $display("FAIL ovf_accepted[%0d]: got %0d want %0d", i, tot[i], exp_acc[i]); end
      n_vec++;
      if (dcnt(i) !== 16'(exp_drop[i]) || dcnt(i) !== 16'(20 - tot[i])) begin
        n_err++; $display("FAIL ovf_drop[%0d]: got %0d want %0d", i, dcnt(i), exp_drop[i]);
      end
    end
  endtask

  task automatic test_clr_drop();
    for (int j = 0; j < 6; j++) begin
      vld = 4'hF;
      clr = (j == 5);
      for (int i = 0; i < NS; i++) rec[i*RECORD_W +: RECORD_W] = mkrec(i, 16'h0400 + j);
      @(negedge clk);
    end
    vld = '0;
    clr = 1'b0;
    n_vec++;
    if (drop !== '0) begin n_err++; $display("FAIL clr_beats_inc: got %h want 0", drop); end
    repeat (30) @(negedge clk);
    n_vec++;
    if (drop !== '0 || out_en !== 1'b0) begin n_err++; $display("FAIL clr_after_drain: drop=%h en=%0b want 0 0", drop, out_en); end
  endtask

  task automatic test_log_en_off();
    int seen;
    seen   = 0;
    log_en = 1'b0;
    vld    = 4'hF;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (out_en === 1'b1) seen++;
    end
    vld    = '0;
    log_en = 1'b1;
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL logoff_out: %0d records emitted want 0", seen); end
    n_vec++;
    if (drop !== '0) begin n_err++; $display("FAIL logoff_drop: got %h want 0", drop); end
  endtask

`ifdef L2MP_LOG_BACKPRESSURE_EN
  task automatic test_backpressure();
    int seq [NS];
    int expq [NS];
    bit pend [NS];
    int stalls;
    int extra;
    bit done;
    stalls = 0;
    extra  = 0;
    apply_reset();
    for (int i = 0; i < NS; i++) begin seq[i] = 0; expq[i] = 0; pend[i] = 1'b0; end
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (out_en === 1'b1) begin
        n_vec++;
        if (out_rec !== mkrec(out_slice, 16'h0200 + expq[out_slice])) begin
          n_err++; $display("FAIL bp_record: slice=%0d got %h want %h", out_slice, out_rec, mkrec(out_slice, 16'h0200 + expq[out_slice]));
        end
        expq[out_slice]++;
      end
      for (int i = 0; i < NS; i++) begin
        if (pend[i]) seq[i]++;
        vld[i] = (seq[i] < 10);
        rec[i*RECORD_W +: RECORD_W] = mkrec(i, 16'h0200 + seq[i]);
        pend[i] = vld[i] && rdy[i];
        if (vld[i] && !rdy[i]) stalls++;
      end
      done = 1'b1;
      for (int i = 0; i < NS; i++) if (expq[i] < 10) done = 1'b0;
      if (done) break;
    end
    vld = '0;
    repeat (4) begin
      @(negedge clk);
      if (out_en === 1'b1) extra++;
    end
    for (int i = 0; i < NS; i++) begin
      n_vec++;
      if (expq[i] != 10) begin n_err++; $display("FAIL bp_count[%0d]: got %0d want 10", i, expq[i]); end
    end
    n_vec++;
    if (stalls == 0) begin n_err++; $display("FAIL bp_stall: in_ready never low, got 0 stalls want >0"); end
    n_vec++;
    if (extra != 0) begin n_err++; $display("FAIL bp_duplicate: %0d extra records want 0", extra); end
    n_vec++;
    if (drop !== '0) begin n_err++; $display("FAIL bp_drop: got %h want 0", drop); end
  endtask
`endif

  task automatic test_reset_midop();
    vld = 4'b0111;
    for (int i = 0; i < NS; i++) rec[i*RECORD_W +: RECORD_W] = mkrec(i, 16'h0300);
    @(negedge clk);
    vld = '0;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_en !== 1'b0 || out_stamp !== 64'd0) begin
      n_err++; $display("FAIL rst_async: en=%0b stamp=%0d want 0 0", out_en, out_stamp);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (out_en !== 1'b0) begin n_err++; $display("FAIL rst_stale[%0d]: out_en=%0b want 0", k, out_en); end
    end
    vld = 4'b0010;
    rec[RECORD_W +: RECORD_W] = mkrec(1, 16'h0301);
    @(negedge clk);
    vld = '0;
    n_vec++;
    if (out_en !== 1'b0) begin n_err++; $display("FAIL rst_latency: out_en=%0b want 0", out_en); end
    @(negedge clk);
    n_vec++;
    if (out_en !== 1'b1 || out_slice !== 2'd1 || out_rec !== mkrec(1, 16'h0301) || out_stamp !== 64'd5) begin
      n_err++; $display("FAIL rst_restart: en=%0b slice=%0d rec=%h stamp=%0d want en=1 slice=1 rec=%h stamp=5",
                        out_en, out_slice, out_rec, out_stamp, mkrec(1, 16'h0301));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_all_slices();
    test_single_stamp100();
    test_same_cycle_pop();
`ifndef L2MP_LOG_BACKPRESSURE_EN
    test_overflow_drops();
    test_clr_drop();
`endif
    test_log_en_off();
`ifdef L2MP_LOG_BACKPRESSURE_EN
    test_backpressure();
    repeat (20) @(negedge clk);
`endif
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
